// File: rtl/deck_shuffler_pkg.sv
// Shared card encoding, suit constants and LFSR constants for the deck shuffler.
package deck_shuffler_pkg;

  localparam int unsigned DECK_SIZE = 52;

  localparam int unsigned RANK_MSB = 6;
  localparam int unsigned RANK_LSB = 3;
  localparam int unsigned SUIT_MSB = 2;
  localparam int unsigned SUIT_LSB = 1;
  localparam int unsigned FACE_BIT = 0;

  localparam logic [1:0] HEARTS   = 2'd0;
  localparam logic [1:0] SPADES   = 2'd1;
  localparam logic [1:0] DIAMONDS = 2'd2;
  localparam logic [1:0] CLUBS    = 2'd3;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Smallest 2^n-1 covering i: smear the top set bit downwards.
  function automatic logic [5:0] draw_mask(input logic [5:0] i);
    logic [5:0] m;
    m = i;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load; holds unless advance is set.
module lfsr16 #(
  parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        advance,
  output logic [15:0] value
);
  import deck_shuffler_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= load_value;
    end else if (advance) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/deck_shuffler.sv
// Builds an ordered deck, Fisher-Yates shuffles it with an LFSR, then streams
// the cards out in index order over a valid/ready handshake.
module deck_shuffler #(
  parameter int unsigned DECK_SIZE    = deck_shuffler_pkg::DECK_SIZE,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  output logic [6:0]  card_out,
  output logic [5:0]  card_index,
  output logic        card_valid,
  input  logic        card_ready,
  output logic        busy,
  output logic        done
);
  import deck_shuffler_pkg::*;

  typedef enum logic [2:0] {StIdle, StFill, StDraw, StSwap, StStream, StDone} state_e;

  localparam logic [5:0] LastIdx = 6'(DECK_SIZE - 1);

  state_e      state_q;
  logic [5:0]  k_q, i_q, j_q;
  logic [3:0]  rank_q;
  logic [1:0]  suit_q;
  logic [6:0]  deck_q [DECK_SIZE];

  logic [15:0] lfsr_value;
  logic        lfsr_load, lfsr_advance;
  logic [15:0] lfsr_seed;
  logic [5:0]  cand;
  logic        accept;
  logic [6:0]  fill_card;
  logic        unused_lfsr_hi;

  assign lfsr_load      = start && (state_q == StIdle || state_q == StDone);
  assign lfsr_advance   = (state_q == StDraw);
  assign lfsr_seed      = (seed == 16'h0000) ? DEFAULT_SEED : seed;
  assign cand           = lfsr_value[5:0] & draw_mask(i_q);
  assign accept         = (cand <= i_q);
  assign unused_lfsr_hi = ^lfsr_value[15:6];

  always_comb begin
    fill_card                    = '0;
    fill_card[RANK_MSB:RANK_LSB] = rank_q;
    fill_card[SUIT_MSB:SUIT_LSB] = suit_q;
    fill_card[FACE_BIT]          = 1'b0;
  end

  lfsr16 #(
    .RESET_VALUE (DEFAULT_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load),
    .load_value (lfsr_seed),
    .advance    (lfsr_advance),
    .value      (lfsr_value)
  );

  // Deck contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == StFill) begin
      deck_q[k_q] <= fill_card;
    end else if (state_q == StSwap) begin
      deck_q[i_q] <= deck_q[j_q];
      deck_q[j_q] <= deck_q[i_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      card_out   <= '0;
      card_index <= '0;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      k_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      rank_q     <= 4'd1;
      suit_q     <= HEARTS;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StFill;
            k_q     <= '0;
            rank_q  <= 4'd1;
            suit_q  <= HEARTS;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StFill: begin
          unique case (suit_q)
            HEARTS:   suit_q <= SPADES;
            SPADES:   suit_q <= DIAMONDS;
            DIAMONDS: suit_q <= CLUBS;
            CLUBS: begin
              suit_q <= HEARTS;
              rank_q <= rank_q + 4'd1;
            end
            default:  suit_q <= HEARTS;
          endcase
          if (k_q == LastIdx) begin
            i_q     <= LastIdx;
            state_q <= StDraw;
          end else begin
            k_q <= k_q + 6'd1;
          end
        end
        StDraw: begin
          if (accept) begin
            j_q     <= cand;
            state_q <= StSwap;
          end
        end
        StSwap: begin
          if (i_q == 6'd1) begin
            card_index <= '0;
            state_q    <= StStream;
          end else begin
            i_q     <= i_q - 6'd1;
            state_q <= StDraw;
          end
        end
        StStream: begin
          // First STREAM cycle only loads the output register.
          if (!card_valid) begin
            card_valid <= 1'b1;
            card_out   <= deck_q[card_index];
          end else if (card_ready) begin
            if (card_index == LastIdx) begin
              card_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state_q    <= StDone;
            end else begin
              card_index <= card_index + 6'd1;
              card_out   <= deck_q[card_index + 6'd1];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Randomized bench for deck_shuffler against an array-based Fisher-Yates model.
module tb_deck_shuffler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [6:0]  card_out;
  logic [5:0]  card_index;
  logic        card_valid;
  logic        card_ready;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_deck [52];
  logic [6:0] cap [52];

  always #5 clk = ~clk;

  deck_shuffler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .card_out   (card_out),
    .card_index (card_index),
    .card_valid (card_valid),
    .card_ready (card_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ordered deck, then Fisher-Yates with rejection sampling on the LFSR low bits.
  function automatic void build_model(input logic [15:0] s);
    logic [15:0] l;
    logic [6:0]  t;
    int          m, j, guard;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int k = 0; k < 52; k++) exp_deck[k] = {4'(k / 4 + 1), 2'(k % 4), 1'b0};
    for (int i = 51; i >= 1; i--) begin
      m = 1;
      while (m < i) m = 2 * m + 1;
      j = i + 1;
      guard = 0;
      while (j > i && guard < 1000) begin
        j = int'(l[5:0]) & m;
        l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        guard++;
      end
      if (j > i) j = i;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[j];
      exp_deck[j] = t;
    end
  endfunction

  task automatic run_deck(input logic [15:0] s, input bit rand_ready, input bit bp,
                          input bit pulse, input bit rst_mid);
    int n_xfer, cyc, force_rdy, cnt;
    bit bp_done;
    build_model(s);
    n_xfer = 0; cyc = 0; force_rdy = 0; bp_done = 0;
    start = 1'b1; seed = s;
    @(negedge clk);
    start = 1'b0; seed = 16'($urandom);
    while (!done && cyc < 4000) begin
      cyc++;
      if (cyc == 10) begin
        check("busy_fill", busy, 1);
        check("valid_fill", card_valid, 0);
      end
      start = pulse && (cyc == 53 || (card_valid && n_xfer == 5));
      if (start) begin
        seed = 16'h0001;
        check("busy_on_pulse", busy, 1);
      end
      if (rst_mid && card_valid && card_index == 6'd20) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_valid", card_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        return;
      end
      if (bp && !bp_done && card_valid && card_index == 6'd10) begin
        card_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_out", card_out, exp_deck[10]);
          check("bp_idx", card_index, 10);
          check("bp_valid", card_valid, 1);
        end
        bp_done = 1;
        force_rdy = 2;
      end
      if (force_rdy == 1) check("bp_next_valid", card_valid, 1);
      if (force_rdy > 0) begin
        card_ready = 1'b1;
        force_rdy--;
      end else begin
        card_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (card_valid && card_ready) begin
        if (n_xfer < 52) begin
          check("card", card_out, exp_deck[n_xfer]);
          check("index", card_index, n_xfer);
          check("face", card_out[0], 0);
          cap[n_xfer] = card_out;
        end else begin
          check("overrun", n_xfer, 51);
        end
        n_xfer++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("xfer_count", n_xfer, 52);
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", card_valid, 0);
    if (n_xfer == 52) begin
      for (int r = 1; r <= 13; r++) begin
        for (int su = 0; su < 4; su++) begin
          cnt = 0;
          for (int k = 0; k < 52; k++)
            if (cap[k][6:3] == 4'(r) && cap[k][2:1] == 2'(su)) cnt++;
          check("perm", cnt, 1);
        end
      end
    end
  endtask

  initial begin
    int ndiff;
    rst = 1'b1; start = 1'b1; seed = 16'h0005; card_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", card_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", card_out, 0);
    check("rst_index", card_index, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", card_valid, 0);

    run_deck(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    build_model(16'hACE1);
    ndiff = 0;
    for (int k = 0; k < 52; k++) if (cap[k] !== exp_deck[k]) ndiff++;
    check("seed_differs", ndiff != 0, 1);

    run_deck(16'hACE1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_deck(16'hACE1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_deck(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_deck(16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_deck(16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
    run_deck(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b1);
    run_deck(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) run_deck(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
